// File: rtl/stu_arb_pkg.sv
// stu_arb_pkg: shared encodings and types for the lane result arbiter
package stu_arb_pkg;
    localparam logic [1:0] CNTL_SOM = 2'b00;
    localparam logic [1:0] CNTL_SOD = 2'b01;
    localparam logic [1:0] CNTL_MOD = 2'b10;
    localparam logic [1:0] CNTL_EOD = 2'b11;
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} stu_arb_state_e;
    typedef logic stu_idx_t;
endpackage

// File: rtl/stu_arb_out_reg.sv
// stu_arb_out_reg: single-entry valid/ready output register with a 1-bit tag
// Ports: load/in_* capture a beat; ready drains it; out_* hold it stable until drained.
module stu_arb_out_reg #(
    parameter int DATA_W = 32,
    parameter int CNTL_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              ready,
    input  logic [CNTL_W-1:0] in_cntl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_mask,
    input  logic              in_tag,
    output logic              out_valid,
    output logic [CNTL_W-1:0] out_cntl,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] out_mask,
    output logic              out_tag
);
    localparam int PW = CNTL_W + 2 * DATA_W + 1;
    logic          valid_q, valid_d;
    logic [PW-1:0] pay_q, pay_d;
    always_comb begin
        valid_d = load || (valid_q && !ready);
        pay_d   = load ? {in_cntl, in_data, in_mask, in_tag} : pay_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
        end
    end
    assign out_valid = valid_q;
    assign {out_cntl, out_data, out_mask, out_tag} = pay_q;
endmodule

// File: rtl/stu_lane_result_arb.sv
// stu_lane_result_arb: packet-granular round-robin share of one PE result lane between two streams
// Ports: stOp__stu__lane_strm{0,1}_* in (valid/cntl/data/mask), stu__stOp__lane_strm{0,1}_ready out;
//        pe__stu__lane_result_* / pe__stu__lane_type out with stu__pe__lane_result_ready in;
//        arb__sys__pkt_cnt{0,1} completed packets, arb__sys__proto_err sticky error.
module stu_lane_result_arb
    import stu_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNTL_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              stOp__stu__lane_strm0_data_valid,
    input  logic [CNTL_W-1:0] stOp__stu__lane_strm0_cntl,
    input  logic [DATA_W-1:0] stOp__stu__lane_strm0_data,
    input  logic [DATA_W-1:0] stOp__stu__lane_strm0_data_mask,
    input  logic              stOp__stu__lane_strm1_data_valid,
    input  logic [CNTL_W-1:0] stOp__stu__lane_strm1_cntl,
    input  logic [DATA_W-1:0] stOp__stu__lane_strm1_data,
    input  logic [DATA_W-1:0] stOp__stu__lane_strm1_data_mask,
    output logic              stu__stOp__lane_strm0_ready,
    output logic              stu__stOp__lane_strm1_ready,
    output logic              pe__stu__lane_result_data_valid,
    output logic [CNTL_W-1:0] pe__stu__lane_result_cntl,
    output logic [DATA_W-1:0] pe__stu__lane_result_data,
    output logic [DATA_W-1:0] pe__stu__lane_result_data_mask,
    output logic              pe__stu__lane_type,
    input  logic              stu__pe__lane_result_ready,
    output logic [CNT_W-1:0]  arb__sys__pkt_cnt0,
    output logic [CNT_W-1:0]  arb__sys__pkt_cnt1,
    output logic              arb__sys__proto_err
);
    stu_arb_state_e    state_q, state_d;
    stu_idx_t          last_q, last_d;
    logic              in_pkt_q, in_pkt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic              v0, v1, sel, sel_valid, oth_valid, can_load, acc, is_start, pkt_end;
    logic [CNTL_W-1:0] sel_cntl;
    assign v0        = stOp__stu__lane_strm0_data_valid;
    assign v1        = stOp__stu__lane_strm1_data_valid;
    assign sel       = state_q == GNT1;
    assign sel_valid = sel ? v1 : v0;
    assign oth_valid = sel ? v0 : v1;
    assign sel_cntl  = sel ? stOp__stu__lane_strm1_cntl : stOp__stu__lane_strm0_cntl;
    // Combinational path from downstream ready lets a draining beat be replaced in the same cycle.
    assign can_load  = !pe__stu__lane_result_data_valid || stu__pe__lane_result_ready;
    assign stu__stOp__lane_strm0_ready = state_q == GNT0 && can_load;
    assign stu__stOp__lane_strm1_ready = state_q == GNT1 && can_load;
    assign acc       = state_q != IDLE && sel_valid && can_load;
    assign is_start  = sel_cntl == CNTL_SOM || sel_cntl == CNTL_SOD;
    assign pkt_end   = acc && (sel_cntl == CNTL_EOD || sel_cntl == CNTL_SOM);
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        in_pkt_d = in_pkt_q;
        err_d    = err_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;
        if (state_q == IDLE)
            state_d = v0 && v1 ? (last_q ? GNT0 : GNT1) : v0 ? GNT0 : v1 ? GNT1 : IDLE;
        if (acc) begin
            // A start beat inside a packet, or a continuation beat outside one, is malformed.
            err_d    = err_q || (in_pkt_q == is_start);
            in_pkt_d = sel_cntl == CNTL_SOD ? 1'b1 : in_pkt_q;
        end
        if (pkt_end) begin
            in_pkt_d = 1'b0;
            last_d   = sel;
            cnt0_d   = sel ? cnt0_q : cnt0_q + 1'b1;
            cnt1_d   = sel ? cnt1_q + 1'b1 : cnt1_q;
            state_d  = oth_valid ? (sel ? GNT0 : GNT1) : sel_valid ? state_q : IDLE;
        end
    end
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            in_pkt_q <= 1'b0;
            err_q    <= 1'b0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            in_pkt_q <= in_pkt_d;
            err_q    <= err_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end
    assign arb__sys__pkt_cnt0  = cnt0_q;
    assign arb__sys__pkt_cnt1  = cnt1_q;
    assign arb__sys__proto_err = err_q;
    stu_arb_out_reg #(.DATA_W(DATA_W), .CNTL_W(CNTL_W)) u_out (
        .clk       (clk),
        .rst       (reset_poweron),
        .load      (acc),
        .ready     (stu__pe__lane_result_ready),
        .in_cntl   (sel_cntl),
        .in_data   (sel ? stOp__stu__lane_strm1_data : stOp__stu__lane_strm0_data),
        .in_mask   (sel ? stOp__stu__lane_strm1_data_mask : stOp__stu__lane_strm0_data_mask),
        .in_tag    (sel),
        .out_valid (pe__stu__lane_result_data_valid),
        .out_cntl  (pe__stu__lane_result_cntl),
        .out_data  (pe__stu__lane_result_data),
        .out_mask  (pe__stu__lane_result_data_mask),
        .out_tag   (pe__stu__lane_type)
    );
endmodule

// File: doc/stu_lane_result_arb.md
# stu_lane_result_arb

Shares one PE upstream stack-bus result lane between the two streaming-op result streams (strm0, strm1) of a lane. It arbitrates round-robin at packet boundaries and holds the grant for the whole packet (SOD..EOD, or a single SOM beat). It forwards beats through one output register with valid/ready flow control and counts completed packets per stream. It sits between the stOp result outputs and the `pe__stu__lane_result_*` port of the PE.

## Interface
- `DATA_W`, 32: result data and mask width (matches `PE_STU_LANE_RESULT_RANGE`).
- `CNTL_W`, 2: control width (matches `COMMON_STD_INTF_CNTL_RANGE`).
- `CNT_W`, 16: width of each per-stream packet counter.

Clock and reset are fixed: one clock; reset is asynchronous and active-high. Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset_poweron`  in  1  asynchronous active-high reset.
- `stOp__stu__lane_strm{0,1}_data_valid`  in  1  beat valid for stream i.
- `stOp__stu__lane_strm{0,1}_cntl`  in  CNTL_W  beat control for stream i.
- `stOp__stu__lane_strm{0,1}_data`  in  DATA_W  beat data for stream i.
- `stOp__stu__lane_strm{0,1}_data_mask`  in  DATA_W  beat mask for stream i.
- `stu__stOp__lane_strm{0,1}_ready`  out  1  stream i beat accepted this cycle when valid&ready.
- `pe__stu__lane_result_data_valid`  out  1  output beat valid.
- `pe__stu__lane_result_cntl`  out  CNTL_W  output beat control.
- `pe__stu__lane_result_data`  out  DATA_W  output beat data.
- `pe__stu__lane_result_data_mask`  out  DATA_W  output beat mask.
- `pe__stu__lane_type`  out  1  stream index of the beat in the output register.
- `stu__pe__lane_result_ready`  in  1  downstream ready.
- `arb__sys__pkt_cnt{0,1}`  out  CNT_W  completed packets per stream.
- `arb__sys__proto_err`  out  1  sticky protocol-error flag.

## Operation
- Control encoding: 2'b00 SOM (single-beat packet), 2'b01 SOD (first beat), 2'b10 MOD (middle beat), 2'b11 EOD (last beat).
- FSM states:
  - IDLE: no stream granted.
  - GNT0: stream 0 holds the lane.
  - GNT1: stream 1 holds the lane.
- `last` is the last-served stream index; reset value 1, so stream 0 wins first.
- IDLE transitions:
  - Only stream i valid: go to GNTi.
  - Both valid: go to GNT(!last).
  - Neither valid: stay in IDLE.
- Input ready: `ready_i` = (state==GNTi) && (!out_valid || `stu__pe__lane_result_ready`). The non-granted ready is always 0.
- Accepted beat: loaded into the output register, and `pe__stu__lane_type` is set to i.
- Packet end: an accepted EOD or SOM beat ends the packet. On that edge:
  - `last` becomes i.
  - `pkt_cnt_i` increments, wrapping at 2^CNT_W.
  - Next state is GNT(!i) if the other stream's valid is high that cycle.
  - Otherwise it is GNTi if stream i's valid is high and an in-packet flag is clear; otherwise IDLE.
  - The in-packet flag is set by SOD and cleared by EOD/SOM.
- Protocol errors:
  - The first beat of a grant is MOD or EOD: set `proto_err`, forward the beat, and end the packet only on EOD.
  - An SOD or SOM arrives while the in-packet flag is set: set `proto_err` and forward the beat.
  - `proto_err` stays set until reset.
- Output register:
  - Loads when an input beat is accepted.
  - Clears valid when `stu__pe__lane_result_ready` is high and no new beat is accepted.
  - Holds otherwise; data, cntl, mask and type stay stable while valid && !ready.

## Timing
- Reset values: all outputs 0, state IDLE, `last`=1, counters 0, in-packet flag 0.
- Reset asserted mid-packet: the packet is dropped and the output beat is discarded, with no partial completion.
- Grant latency: a valid rising at cycle N in IDLE gives grant at N+1, beat accepted at N+1, output valid at N+2.
- Back-to-back packets inside a grant, or across a grant switch, have zero bubble cycles.
- Throughput is one beat per cycle while downstream ready is held high.
- Downstream ready low with the output valid: both input readys are low the same cycle (combinational path from `stu__pe__lane_result_ready` to `ready_i`).
- Arbitration is never re-evaluated mid-packet; a valid on the other stream waits until EOD/SOM.

## Structure
- Package `stu_arb_pkg` holds:
  - the CNTL encoding localparams (SOM/SOD/MOD/EOD);
  - the state enum `stu_arb_state_e` {IDLE, GNT0, GNT1};
  - the stream-index typedef.
- Sub-module `stu_arb_out_reg`: single-entry valid/ready output register, parameterized by DATA_W, CNTL_W and a 1-bit tag.
- Top level holds the FSM, the `last` pointer, the in-packet flag, the counters and the error logic.

## Test plan
- **Single stream:** strm0 sends SOD,MOD,EOD with data 0x11,0x22,0x33; ready always high. Output at cycles 2,3,4; type=0; `pkt_cnt0`=1.
- **Contention:** both streams request 3-beat packets from reset. Strm0 is served first, strm1 immediately after EOD with no bubble, then strm0 again; counters both reach 2 after two packets each.
- **Backpressure:** downstream ready low for 5 cycles mid-packet. The output beat is held stable, input readys are 0, no beat is lost or duplicated, and order is preserved.
- **SOM burst:** strm1 sends 4 SOM beats while strm0 is idle. They are forwarded back-to-back; `pkt_cnt1`=4.
- **Protocol error:** strm0 starts with MOD, then EOD. Both beats are forwarded and `proto_err`=1 stays set; a following clean packet is forwarded and `proto_err` is still 1.
- **Reset mid-packet:** assert reset after SOD,MOD. All outputs are 0 immediately (asynchronously); after release, state is IDLE and a new strm1 SOM is granted in 1 cycle.
